// File: rtl/display_scan_ctrl_if.sv
// Digit data in, multiplexed digit/anode drive out.
// master = value registers + decoder side, slave = scan controller.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  localparam int IW = $clog2(DIGITS);

  logic [4*DIGITS-1:0] Hexs;
  logic [DIGITS-1:0]   Point;
  logic [DIGITS-1:0]   Les;
  logic [DIGITS-1:0]   Blink;
  logic [3:0]          Hex;
  logic                p;
  logic                LE;
  logic [DIGITS-1:0]   AN;
  logic [IW-1:0]       scan_idx;

  modport master (
    output Hexs, Point, Les, Blink,
    input  Hex, p, LE, AN, scan_idx
  );

  modport slave (
    input  Hexs, Point, Les, Blink,
    output Hex, p, LE, AN, scan_idx
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Self-clocked N-digit 7-seg scan controller with guard and blink.
// Optional leading-zero blanking: define DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 50000,
  parameter int GUARD     = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  display_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [PW-1:0] PS_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_DIV - 1);

  logic [PW-1:0]     ps_q, ps_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     bc_q, bc_d;
  logic              bp_q, bp_d;
  logic [3:0]        hex_q, hex_d;
  logic              p_q, p_d;
  logic              le_q, le_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic tick;
  logic bwrap;
  logic in_guard;
  logic blink_off;
  logic lz_off;

  assign tick  = (ps_q == PS_LAST);
  assign bwrap = (bc_q == BL_LAST);

  if (GUARD > 0) begin : g_guard
    assign in_guard = (ps_q < PW'(GUARD));
  end else begin : g_noguard
    assign in_guard = 1'b0;
  end

  assign blink_off = bus.Blink[idx_q] & bp_q;

`ifdef DISPLAY_LZ_BLANK_EN
  // zr[i]: digit i and everything above it are blank-eligible zeros
  logic [DIGITS:0] zr;

  assign zr[DIGITS] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign zr[i] = zr[i+1]
                 & (bus.Hexs[4*i +: 4] == 4'h0)
                 & ~bus.Point[i]
                 & ~bus.Blink[i];
  end

  assign lz_off = (idx_q != '0) & zr[idx_q];
`else
  assign lz_off = 1'b0;
`endif

  always_comb begin
    ps_d  = ps_q;
    idx_d = idx_q;
    bc_d  = bc_q;
    bp_d  = bp_q;
    if (en) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      bc_d = bwrap ? '0 : bc_q + 1'b1;
      if (bwrap) begin
        bp_d = ~bp_q;
      end
    end
  end

  always_comb begin
    hex_d = hex_q;
    p_d   = p_q;
    le_d  = le_q;
    an_d  = '1;
    if (en) begin
      hex_d = bus.Hexs[{idx_q, 2'b00} +: 4];
      p_d   = bus.Point[idx_q];
      le_d  = bus.Les[idx_q];
      if (!(in_guard | blink_off | lz_off)) begin
        an_d = ~(DIGITS'(1) << idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q  <= '0;
      idx_q <= '0;
      bc_q  <= '0;
      bp_q  <= 1'b0;
      hex_q <= 4'h0;
      p_q   <= 1'b0;
      le_q  <= 1'b0;
      an_q  <= '1;
    end else begin
      ps_q  <= ps_d;
      idx_q <= idx_d;
      bc_q  <= bc_d;
      bp_q  <= bp_d;
      hex_q <= hex_d;
      p_q   <= p_d;
      le_q  <= le_d;
      an_q  <= an_d;
    end
  end

  assign bus.Hex      = hex_q;
  assign bus.p        = p_q;
  assign bus.LE       = le_q;
  assign bus.AN       = an_q;
  assign bus.scan_idx = idx_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two configurations vs. a cycle-count model.
// Honours DISPLAY_LZ_BLANK_EN in the reference model too.
module tb_display_scan_ctrl;
  localparam int DA = 4, CA = 4, GA = 1, BA = 8;
  localparam int DB = 5, CB = 3, GB = 0, BB = 6;

  typedef struct {
    logic [3:0]  hex;
    logic        p;
    logic        le;
    logic [15:0] an;
  } exp_t;

  logic clk = 1'b0;
  logic rsta, rstb, ena, enb;
  int   n_chk = 0;
  int   n_err = 0;
  int   na, nb;
  exp_t ea, eb;
  int   offa, offb;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.DIGITS(DA)) ifa ();
  display_scan_ctrl_if #(.DIGITS(DB)) ifb ();

  display_scan_ctrl #(
    .DIGITS(DA), .CLK_DIV(CA), .GUARD(GA), .BLINK_DIV(BA)
  ) u_a (
    .clk(clk), .rst(rsta), .en(ena), .bus(ifa)
  );

  display_scan_ctrl #(
    .DIGITS(DB), .CLK_DIV(CB), .GUARD(GB), .BLINK_DIV(BB)
  ) u_b (
    .clk(clk), .rst(rstb), .en(enb), .bus(ifb)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output after one edge, given n enabled cycles since reset.
  function automatic exp_t model(int d, int cd, int g, int bd,
                                 int n, bit en, bit rst,
                                 logic [63:0] hx, logic [15:0] pt,
                                 logic [15:0] le, logic [15:0] bl,
                                 exp_t prev);
    exp_t e = prev;
    int idx, pre, ph;
    logic [15:0] mask;
    bit z;
    mask = 16'((32'd1 << d) - 1);
    if (rst || !en) begin
      e.an = mask;
      if (rst) begin
        e.hex = 4'h0;
        e.p   = 1'b0;
        e.le  = 1'b0;
      end
      return e;
    end
    pre   = n % cd;
    idx   = (n / cd) % d;
    ph    = (n / bd) % 2;
    e.hex = hx[idx*4 +: 4];
    e.p   = pt[idx];
    e.le  = le[idx];
    e.an  = mask & ~(16'd1 << idx);
    if (pre < g) e.an = mask;
    if (bl[idx] && ph == 1) e.an = mask;
    z = 1'b0;
`ifdef DISPLAY_LZ_BLANK_EN
    if (idx > 0) begin
      z = 1'b1;
      for (int j = idx; j < d; j++)
        if (hx[j*4 +: 4] != 0 || pt[j] || bl[j]) z = 1'b0;
    end
`endif
    if (z) e.an = mask;
    return e;
  endfunction

  function automatic logic [63:0] rnd_hex(int d);
    logic [63:0] h;
    int top;
    h   = {$urandom, $urandom};
    top = $urandom_range(0, d);
    for (int j = top; j < d; j++) h[j*4 +: 4] = 4'h0;
    return h;
  endfunction

  task automatic step();
    exp_t xa, xb;
    xa = model(DA, CA, GA, BA, na, ena, rsta,
               64'(ifa.Hexs), 16'(ifa.Point),
               16'(ifa.Les), 16'(ifa.Blink), ea);
    xb = model(DB, CB, GB, BB, nb, enb, rstb,
               64'(ifb.Hexs), 16'(ifb.Point),
               16'(ifb.Les), 16'(ifb.Blink), eb);
    @(posedge clk);
    #1;
    ea = xa;
    eb = xb;
    if (rsta) na = 0; else if (ena) na++;
    if (rstb) nb = 0; else if (enb) nb++;
    check("a_hex", 32'(ifa.Hex), 32'(ea.hex));
    check("a_p",   32'(ifa.p),   32'(ea.p));
    check("a_le",  32'(ifa.LE),  32'(ea.le));
    check("a_an",  32'(ifa.AN),  32'(ea.an));
    check("a_idx", 32'(ifa.scan_idx), 32'((na / CA) % DA));
    check("a_1hot", 32'($countones(~ifa.AN) <= 1), 32'd1);
    check("b_hex", 32'(ifb.Hex), 32'(eb.hex));
    check("b_p",   32'(ifb.p),   32'(eb.p));
    check("b_le",  32'(ifb.LE),  32'(eb.le));
    check("b_an",  32'(ifb.AN),  32'(eb.an));
    check("b_idx", 32'(ifb.scan_idx), 32'((nb / CB) % DB));
    @(negedge clk);
  endtask

  logic [3:0] an_tab [18];
  logic [3:0] hx_tab [18];

  initial begin
    an_tab = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    hx_tab = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2,
               4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1};
    na = 0; nb = 0; offa = 0; offb = 0;
    ea = '{hex: 4'h0, p: 1'b0, le: 1'b0, an: 16'hF};
    eb = '{hex: 4'h0, p: 1'b0, le: 1'b0, an: 16'h1F};
    rsta = 1'b1; rstb = 1'b1; ena = 1'b1; enb = 1'b1;
    ifa.Hexs = 16'h4321; ifa.Point = '0; ifa.Les = '0; ifa.Blink = '0;
    ifb.Hexs = 20'h54321; ifb.Point = '0; ifb.Les = '0; ifb.Blink = '0;
    @(negedge clk);

    // Directed start-up sequence of the 4-digit instance
    for (int i = 0; i < 18; i++) begin
      step();
      rsta = 1'b0;
      rstb = 1'b0;
      check("dir_an",  32'(ifa.AN),  32'(an_tab[i]));
      check("dir_hex", 32'(ifa.Hex), 32'(hx_tab[i]));
    end

    for (int c = 0; c < 4000; c++) begin
      rsta = ($urandom_range(0, 199) == 0);
      rstb = ($urandom_range(0, 199) == 0);
      if (offa > 0) offa--;
      else if ($urandom_range(0, 49) == 0) offa = $urandom_range(1, 12);
      if (offb > 0) offb--;
      else if ($urandom_range(0, 49) == 0) offb = $urandom_range(1, 12);
      ena = (offa == 0);
      enb = (offb == 0);
      if ($urandom_range(0, 7) == 0) ifa.Hexs = 16'(rnd_hex(DA));
      if ($urandom_range(0, 7) == 0) ifb.Hexs = 20'(rnd_hex(DB));
      if ($urandom_range(0, 63) == 0)
        ifa.Blink = 4'($urandom & $urandom);
      if ($urandom_range(0, 63) == 0)
        ifb.Blink = 5'($urandom & $urandom);
      ifa.Point = 4'($urandom & $urandom & $urandom);
      ifb.Point = 5'($urandom & $urandom & $urandom);
      ifa.Les   = 4'($urandom);
      ifb.Les   = 5'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
